neuron_controller: RTL and testbench
====================================

Name: neuron_controller

Overview:
- Control-side counterpart of the neuron MAC datapath (input/weight selection, 8x8 multiplier, 16-bit accumulator, activation function).
- Drives the datapath's `index`, `ld` and `reg_rst` inputs to sweep all N input/weight pairs through the multiply-accumulate.
- Captures the activated 16-bit result and presents it downstream on a valid/ready handshake.
- Sits between the layer sequencer (`start`) and the neuron output consumer.

Parameters:
- N, 16, number of input/weight pairs per neuron; legal range 1..65535.
- IDX_W, 16, width of `index`; fixed to match the datapath `index` port.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request one neuron evaluation; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- index  output  IDX_W  pair select to datapath.
- ld  output  1  accumulator load enable to datapath.
- reg_rst  output  1  accumulator clear to datapath (synchronous clear in the datapath register).
- result_in  input  16  activated accumulator value from datapath (combinational from the accumulator).
- result_out  output  16  captured neuron result.
- result_valid  output  1  result_out holds a new result.
- result_ready  input  1  downstream accepts result_out.

Behaviour:
- Reset, rst=0, asynchronous, any state:
  - state=IDLE, index=0, ld=0, reg_rst=0, busy=0, result_valid=0, result_out=0.
  - Reset mid-operation aborts with no result produced.
- All outputs are registered or decoded directly from the state register; no combinational path from result_ready or start to any output.
- States:
  - IDLE: ld=0, reg_rst=0, index=0. start=1 at an edge moves to CLEAR.
  - CLEAR (exactly 1 cycle): reg_rst=1, ld=0, index=0. Moves to ACCUM.
  - ACCUM (exactly N cycles): ld=1, reg_rst=0. index = 0,1,...,N-1, incrementing by 1 each cycle. At the edge ending the cycle with index=N-1, moves to SETTLE.
  - SETTLE (exactly 1 cycle): ld=0, index holds N-1. At its ending edge, result_out <= result_in, result_valid <= 1, moves to DONE.
  - DONE: ld=0, reg_rst=0, result_out and result_valid held stable. On an edge with result_ready=1: result_valid <= 0, moves to IDLE. result_out keeps its last value until the next capture.
- Latency, counted from the edge that samples start=1 as E0:
  - reg_rst=1 in the cycle after E0.
  - ld=1 for N cycles after that.
  - result_valid=1 after edge E(N+2). For N=16, that is 18 edges.
- Throughput: minimum one result per N+4 cycles (IDLE revisited for at least one cycle between operations).
- start while busy=1 is ignored and not queued. start held high continuously relaunches on the first IDLE cycle.
- result_ready while result_valid=0 has no effect.
- N=1: ACCUM lasts one cycle with index=0, then SETTLE.
- Index counter is IDX_W wide. It never exceeds N-1 and never wraps within an operation.

Test Plan:
- Reset and idle: assert rst=0 mid-cycle → all outputs 0 immediately, without waiting for a clock edge. Release rst, hold start=0 for 10 cycles → busy=0, ld=0, index=0 throughout.
- Single run, N=16: pulse start 1 cycle, drive result_in=16'h0123 from the datapath model, hold result_ready=0 → expect:
  - reg_rst high for 1 cycle, then ld high for exactly 16 cycles with index 0..15.
  - result_valid=1 after edge E18 with result_out=16'h0123.
  - Values held for 5 cycles; result_ready=1 for 1 cycle → result_valid=0, busy=0 on the next cycle.
- Integrated with the datapath, all inputs=2 and weights=3 → accumulator sums to 96 before activation; result_out equals the activation of 96.
- start pulsed at index=7 during ACCUM → no restart, index continues 8..15, single result produced.
- rst=0 asserted at index=10 → outputs zero asynchronously, no result_valid. After release plus start → full fresh sequence from index 0.
- N=1 build: start → reg_rst 1 cycle, ld 1 cycle with index=0, result_valid after E3. start held high continuously → back-to-back runs every 5 cycles while result_ready=1.

Source files
------------

// File: rtl/neuron_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// neuron_controller
//
// Control side of the neuron MAC datapath. One evaluation runs in this order:
//   1. Clear the accumulator for one cycle.
//   2. Sweep index 0..N-1 with ld high, one pair per cycle.
//   3. Wait one settle cycle so the activation output reflects the last add.
//   4. Capture result_in and offer it downstream until it is accepted.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        request one evaluation; only sampled in IDLE
//   busy         high in every state except IDLE
//   index        pair select to the datapath (IDX_W bits)
//   ld           accumulator load enable to the datapath
//   reg_rst      accumulator clear to the datapath
//   result_in    activated accumulator value from the datapath
//   result_out   captured neuron result
//   result_valid result_out holds a result not yet accepted
//   result_ready downstream accepts result_out
//   state_dbg    current FSM state (0 IDLE, 1 CLEAR, 2 ACCUM, 3 SETTLE, 4 DONE)
//
// Handshake: result_out is transferred on a rising edge where result_valid
// and result_ready are both high. result_valid stays high, and result_out
// stays stable, until that edge. result_ready has no effect while
// result_valid is low.
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from start or result_ready to any output.
// N must lie in 1..65535 so that N-1 fits in the index counter.
// -----------------------------------------------------------------------------
module neuron_controller #(
   parameter int N     = 16,
   parameter int IDX_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic [IDX_W-1:0] index,
   output logic             ld,
   output logic             reg_rst,
   input  logic [15:0]      result_in,
   output logic [15:0]      result_out,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_ACCUM  = 3'd2,
      S_SETTLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_t state;
   state_t state_next;
   logic   at_last;

   assign at_last   = (index == LAST_IDX);
   assign state_dbg = state;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start)        state_next = S_CLEAR;
         S_CLEAR:                    state_next = S_ACCUM;
         S_ACCUM:  if (at_last)      state_next = S_SETTLE;
         S_SETTLE:                   state_next = S_DONE;
         S_DONE:   if (result_ready) state_next = S_IDLE;
         default:                    state_next = S_IDLE;
      endcase
   end

   // Output decode from the state register
   always_comb begin
      busy         = 1'b1;
      ld           = 1'b0;
      reg_rst      = 1'b0;
      result_valid = 1'b0;
      case (state)
         S_IDLE:  busy         = 1'b0;
         S_CLEAR: reg_rst      = 1'b1;
         S_ACCUM: ld           = 1'b1;
         S_DONE:  result_valid = 1'b1;
         default: ;
      endcase
   end

   // Index counter: zero until the sweep starts, counts once per ACCUM cycle,
   // stops at N-1 (so it is still N-1 during SETTLE), then returns to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         index <= '0;
      end else begin
         case (state)
            S_ACCUM:  if (!at_last) index <= index + IDX_W'(1);
            S_SETTLE: index <= '0;
            default:  index <= '0;
         endcase
      end
   end

   // Result capture at the end of the settle cycle; held until the next capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_out <= '0;
      end else if (state == S_SETTLE) begin
         result_out <= result_in;
      end
   end

endmodule

// File: tb/tb_neuron_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_neuron_controller
//
// Two controller instances share clock and reset: dut (N=16) driving a small
// MAC datapath model, and dut_1 (N=1) for the minimum-length and
// back-to-back cases. Inputs change 1 ns after a rising edge and outputs are
// sampled there as well.
// -----------------------------------------------------------------------------
module tb_neuron_controller;

   localparam int N = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // N=16 instance
   logic        start = 1'b0;
   logic        ready = 1'b0;
   logic [15:0] result_in;
   logic        busy, ld, reg_rst, valid;
   logic [15:0] index, result_out;
   logic [2:0]  state_dbg;

   // N=1 instance
   logic        start_1 = 1'b0;
   logic        ready_1 = 1'b0;
   logic [15:0] result_in_1 = 16'h0;
   logic        busy_1, ld_1, reg_rst_1, valid_1;
   logic [15:0] index_1, result_out_1;
   logic [2:0]  state_dbg_1;

   neuron_controller #(.N(N), .IDX_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .index(index),
      .ld(ld), .reg_rst(reg_rst), .result_in(result_in),
      .result_out(result_out), .result_valid(valid),
      .result_ready(ready), .state_dbg(state_dbg)
   );

   neuron_controller #(.N(1), .IDX_W(16)) dut_1 (
      .clk(clk), .rst(rst), .start(start_1), .busy(busy_1), .index(index_1),
      .ld(ld_1), .reg_rst(reg_rst_1), .result_in(result_in_1),
      .result_out(result_out_1), .result_valid(valid_1),
      .result_ready(ready_1), .state_dbg(state_dbg_1)
   );

   // Datapath model: inputs x, weights w, 16-bit accumulator, ReLU activation.
   int                 x_arr[N];
   int                 w_arr[N];
   logic signed [15:0] acc;
   logic               use_dp = 1'b0;
   logic [15:0]        fixed_val = 16'h0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         acc <= '0;
      else if (reg_rst) acc <= '0;
      else if (ld)      acc <= acc + 16'(x_arr[index[3:0]] * w_arr[index[3:0]]);
   end

   always_comb begin
      result_in = fixed_val;
      if (use_dp) result_in = acc[15] ? 16'h0 : acc;
   end

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      #1;
      checks++;
      if ({busy, ld, reg_rst, valid} !== 4'b0 || index !== 16'h0 || result_out !== 16'h0) begin
         failures++;
         $display("FAIL reset_por: busy=%b ld=%b reg_rst=%b valid=%b index=%0d out=%h, want all 0",
                  busy, ld, reg_rst, valid, index, result_out);
      end
      #2 rst = 1'b1;
      tick();
      // Launch both instances, then pull reset mid-cycle during the run.
      start = 1'b1; start_1 = 1'b1;
      tick();
      start = 1'b0; start_1 = 1'b0;
      tick();
      tick();
      #3 rst = 1'b0;
      #1;
      checks++;
      if ({busy, ld, reg_rst, valid} !== 4'b0 || index !== 16'h0 || result_out !== 16'h0) begin
         failures++;
         $display("FAIL reset_async: busy=%b ld=%b reg_rst=%b valid=%b index=%0d out=%h, want all 0",
                  busy, ld, reg_rst, valid, index, result_out);
      end
      checks++;
      if ({busy_1, ld_1, reg_rst_1, valid_1} !== 4'b0 || index_1 !== 16'h0 || result_out_1 !== 16'h0) begin
         failures++;
         $display("FAIL reset_async_n1: busy=%b ld=%b reg_rst=%b valid=%b index=%0d out=%h, want all 0",
                  busy_1, ld_1, reg_rst_1, valid_1, index_1, result_out_1);
      end
      #2 rst = 1'b1;
      tick();
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (busy !== 1'b0 || ld !== 1'b0 || reg_rst !== 1'b0 || index !== 16'h0) begin
            failures++;
            $display("FAIL idle_hold c=%0d: busy=%b ld=%b reg_rst=%b index=%0d, want 0 0 0 0",
                     c, busy, ld, reg_rst, index);
         end
         tick();
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_single_run();
      logic        e_rr, e_ld, e_valid;
      logic [15:0] e_idx;
      use_dp = 1'b0; fixed_val = 16'h0123; ready = 1'b0;
      start = 1'b1;
      tick();                          // E0 has sampled start
      start = 1'b0;
      // Cycle k lies between edges E(k) and E(k+1).
      for (int k = 0; k <= N + 6; k++) begin
         e_rr    = (k == 0);
         e_ld    = (k >= 1 && k <= N);
         e_valid = (k >= N + 2);
         e_idx   = (k >= 1 && k <= N) ? 16'(k - 1) : ((k == N + 1) ? 16'(N - 1) : 16'h0);
         checks++;
         if (reg_rst !== e_rr || ld !== e_ld || valid !== e_valid || busy !== 1'b1 ||
             (k <= N + 1 && index !== e_idx) || (e_valid && result_out !== 16'h0123)) begin
            failures++;
            $display("FAIL single_run k=%0d: rr=%b ld=%b valid=%b busy=%b idx=%0d out=%h, want rr=%b ld=%b valid=%b busy=1 idx=%0d out=0123",
                     k, reg_rst, ld, valid, busy, index, result_out, e_rr, e_ld, e_valid, e_idx);
         end
         tick();
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || result_out !== 16'h0123) begin
         failures++;
         $display("FAIL single_accept: valid=%b busy=%b out=%h, want valid=0 busy=0 out=0123",
                  valid, busy, result_out);
      end
      tick();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_dp_integration();
      int          sum;
      int          n;
      logic [15:0] exp;
      use_dp = 1'b1;
      for (int run = 0; run < 4; run++) begin
         sum = 0;
         for (int i = 0; i < N; i++) begin
            x_arr[i] = (run == 0) ? 2 : int'($urandom_range(0, 15));
            w_arr[i] = (run == 0) ? 3 : int'($urandom_range(0, 15)) - 8;
            sum += x_arr[i] * w_arr[i];
         end
         exp_q.push_back((sum < 0) ? 16'h0 : 16'(sum));
         start = 1'b1;
         tick();
         start = 1'b0;
         n = 0;
         while (valid !== 1'b1 && n < N + 10) begin
            tick();
            n++;
         end
         exp = exp_q.pop_front();
         checks++;
         if (valid !== 1'b1) begin
            failures++;
            $display("FAIL dp_timeout run=%0d: valid=%b, want 1 within %0d cycles", run, valid, N + 10);
         end else if (result_out !== exp || n != N + 2) begin
            failures++;
            $display("FAIL dp_result run=%0d: out=%0d after %0d cycles, want %0d after %0d",
                     run, result_out, n, exp, N + 2);
         end
         ready = 1'b1;
         tick();
         ready = 1'b0;
         tick();
      end
      use_dp = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_start_ignored();
      int n;
      fixed_val = 16'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(ld === 1'b1 && index === 16'd7) && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (!(ld === 1'b1 && index === 16'd7)) begin
         failures++;
         $display("FAIL ignore_reach7: ld=%b index=%0d, want ld=1 index=7", ld, index);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 8; i < N; i++) begin
         checks++;
         if (ld !== 1'b1 || reg_rst !== 1'b0 || index !== 16'(i)) begin
            failures++;
            $display("FAIL ignore_seq: ld=%b rr=%b index=%0d, want ld=1 rr=0 index=%0d",
                     ld, reg_rst, index, i);
         end
         tick();
      end
      checks++;
      if (ld !== 1'b0 || valid !== 1'b0 || index !== 16'(N - 1)) begin
         failures++;
         $display("FAIL ignore_settle: ld=%b valid=%b index=%0d, want 0 0 %0d", ld, valid, index, N - 1);
      end
      tick();
      checks++;
      if (valid !== 1'b1 || result_out !== fixed_val) begin
         failures++;
         $display("FAIL ignore_result: valid=%b out=%h, want 1 %h", valid, result_out, fixed_val);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_queue c=%0d: busy=%b valid=%b, want 0 0", c, busy, valid);
         end
         tick();
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset_mid();
      int n;
      fixed_val = 16'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (index !== 16'd10 && n < 30) begin
         tick();
         n++;
      end
      #3 rst = 1'b0;
      #1;
      checks++;
      if ({busy, ld, reg_rst, valid} !== 4'b0 || index !== 16'h0) begin
         failures++;
         $display("FAIL midreset_async: busy=%b ld=%b rr=%b valid=%b index=%0d, want all 0",
                  busy, ld, reg_rst, valid, index);
      end
      #2 rst = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_idle c=%0d: busy=%b valid=%b, want 0 0", c, busy, valid);
         end
         tick();
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (reg_rst !== 1'b1 || ld !== 1'b0) begin
         failures++;
         $display("FAIL midreset_clear: rr=%b ld=%b, want 1 0", reg_rst, ld);
      end
      tick();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (ld !== 1'b1 || index !== 16'(i)) begin
            failures++;
            $display("FAIL midreset_seq: ld=%b index=%0d, want 1 %0d", ld, index, i);
         end
         tick();
      end
      tick();
      checks++;
      if (valid !== 1'b1 || result_out !== fixed_val) begin
         failures++;
         $display("FAIL midreset_result: valid=%b out=%h, want 1 %h", valid, result_out, fixed_val);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      tick();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_n1_back_to_back();
      int          ph;
      int          n;
      logic [15:0] exp_cap;
      exp_cap = 16'h0;
      start_1 = 1'b1;
      ready_1 = 1'b1;
      tick();                          // E0
      // With start and ready both held high the sequence repeats every 5 cycles:
      // clear, accumulate, settle, done, idle.
      for (int k = 0; k < 15; k++) begin
         ph = k % 5;
         checks++;
         if (busy_1 !== (ph != 4) || reg_rst_1 !== (ph == 0) || ld_1 !== (ph == 1) ||
             valid_1 !== (ph == 3) || index_1 !== 16'h0 ||
             (ph == 3 && result_out_1 !== exp_cap)) begin
            failures++;
            $display("FAIL n1_b2b k=%0d: busy=%b rr=%b ld=%b valid=%b idx=%0d out=%h, want busy=%b rr=%b ld=%b valid=%b idx=0 out=%h",
                     k, busy_1, reg_rst_1, ld_1, valid_1, index_1, result_out_1,
                     ph != 4, ph == 0, ph == 1, ph == 3, exp_cap);
         end
         result_in_1 = 16'($urandom);
         if (ph == 2) exp_cap = result_in_1;
         tick();
      end
      start_1 = 1'b0;
      n = 0;
      while (busy_1 !== 1'b0 && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (busy_1 !== 1'b0) begin
         failures++;
         $display("FAIL n1_drain: busy=%b, want 0 within 10 cycles", busy_1);
      end
      ready_1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_run();
      test_dp_integration();
      test_start_ignored();
      test_reset_mid();
      test_n1_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
